// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys K16..K1
// produced on the fly by right-rotating the PC-1 halves. Also holds sbox1..sbox8.

module sbox_lut #(
   parameter logic [255:0] TABLE = '0
) (
   input  logic [5:0] i_data,
   output logic [3:0] o_data
);
   // row = outer bits, column = inner four bits; entry 0 is the top nibble
   logic [5:0] w_idx;
   assign w_idx  = {i_data[5], i_data[0], i_data[4:1]};
   assign o_data = TABLE[{~w_idx, 2'b00} +: 4];
endmodule

module sbox1 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox2 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox3 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox4 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox5 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox6 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox7 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module sbox8 (input logic [5:0] i_data, output logic [3:0] o_data);
   sbox_lut #(.TABLE(256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B))
      u_lut (.i_data(i_data), .o_data(o_data));
endmodule

module des_decrypt_core (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [63:0] i_ciphertext,
   input  logic [63:0] i_key,
   output logic        o_ready,
   output logic        o_valid,
   output logic [63:0] o_plaintext
);
   localparam int unsigned BLK_W  = 64;
   localparam int unsigned HALF_W = 32;
   localparam int unsigned CD_W   = 28;
   localparam int unsigned KS_W   = 56;
   localparam int unsigned SK_W   = 48;
   localparam int unsigned K_W    = 4;

   // Tables list the 1-based DES source bit for each output bit, DES bit 1 = MSB.
   localparam int unsigned IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int unsigned FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int unsigned E_T [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int unsigned P_T [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int unsigned PC1_T [56] = '{
      57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int unsigned PC2_T [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

   function automatic logic [BLK_W-1:0] f_ip(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] f_fp(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
      return y;
   endfunction

   function automatic logic [SK_W-1:0] f_e(input logic [HALF_W-1:0] x);
      logic [SK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
      return y;
   endfunction

   function automatic logic [HALF_W-1:0] f_p(input logic [HALF_W-1:0] x);
      logic [HALF_W-1:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
      return y;
   endfunction

   function automatic logic [KS_W-1:0] f_pc1(input logic [BLK_W-1:0] x);
      logic [KS_W-1:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [SK_W-1:0] f_pc2(input logic [KS_W-1:0] x);
      logic [SK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   function automatic logic [CD_W-1:0] f_rotr(input logic [CD_W-1:0] x, input logic [1:0] n);
      case (n)
         2'd0:    return x;
         2'd1:    return {x[0], x[CD_W-1:1]};
         default: return {x[1:0], x[CD_W-1:2]};
      endcase
   endfunction

   typedef enum logic {S_IDLE, S_ROUND} state_t;

   state_t             r_state, w_state_next;
   logic [HALF_W-1:0]  r_l, r_r, w_l_next, w_r_next;
   logic [CD_W-1:0]    r_c, r_d, w_c_next, w_d_next;
   logic [K_W-1:0]     r_k, w_k_next;
   logic [BLK_W-1:0]   r_pt, w_pt_next;
   logic               r_valid, w_valid_next;
   logic               r_ready, w_ready_next;

   logic [BLK_W-1:0]   w_ip;
   logic [KS_W-1:0]    w_pc1;
   logic [1:0]         w_rot;
   logic [CD_W-1:0]    w_c_rot, w_d_rot;
   logic [SK_W-1:0]    w_subkey, w_sb_in;
   logic [HALF_W-1:0]  w_sb_out, w_f, w_l_new, w_r_new;
   logic [BLK_W-1:0]   w_fp;

   assign w_ip  = f_ip(i_ciphertext);
   assign w_pc1 = f_pc1(i_key);

   // Right-rotation schedule walks the encrypt key schedule backwards: K16 first.
   assign w_rot    = (r_k == 4'd0) ? 2'd0 :
                     ((r_k == 4'd1) || (r_k == 4'd8) || (r_k == 4'd15)) ? 2'd1 : 2'd2;
   assign w_c_rot  = f_rotr(r_c, w_rot);
   assign w_d_rot  = f_rotr(r_d, w_rot);
   assign w_subkey = f_pc2({w_c_rot, w_d_rot});
   assign w_sb_in  = f_e(r_r) ^ w_subkey;

   sbox1 u_sbox1 (.i_data(w_sb_in[47:42]), .o_data(w_sb_out[31:28]));
   sbox2 u_sbox2 (.i_data(w_sb_in[41:36]), .o_data(w_sb_out[27:24]));
   sbox3 u_sbox3 (.i_data(w_sb_in[35:30]), .o_data(w_sb_out[23:20]));
   sbox4 u_sbox4 (.i_data(w_sb_in[29:24]), .o_data(w_sb_out[19:16]));
   sbox5 u_sbox5 (.i_data(w_sb_in[23:18]), .o_data(w_sb_out[15:12]));
   sbox6 u_sbox6 (.i_data(w_sb_in[17:12]), .o_data(w_sb_out[11:8]));
   sbox7 u_sbox7 (.i_data(w_sb_in[11:6]),  .o_data(w_sb_out[7:4]));
   sbox8 u_sbox8 (.i_data(w_sb_in[5:0]),   .o_data(w_sb_out[3:0]));

   assign w_f     = f_p(w_sb_out);
   assign w_l_new = r_r;
   assign w_r_new = r_l ^ w_f;
   assign w_fp    = f_fp({w_r_new, w_l_new});

   // Next-state and datapath update
   always_comb begin
      w_state_next = r_state;
      w_l_next     = r_l;
      w_r_next     = r_r;
      w_c_next     = r_c;
      w_d_next     = r_d;
      w_k_next     = r_k;
      w_pt_next    = r_pt;
      w_valid_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_l_next     = w_ip[63:32];
               w_r_next     = w_ip[31:0];
               w_c_next     = w_pc1[55:28];
               w_d_next     = w_pc1[27:0];
               w_k_next     = '0;
               w_state_next = S_ROUND;
            end
         end
         S_ROUND: begin
            w_l_next = w_l_new;
            w_r_next = w_r_new;
            w_c_next = w_c_rot;
            w_d_next = w_d_rot;
            w_k_next = r_k + 4'd1;
            if (r_k == 4'd15) begin
               w_pt_next    = w_fp;
               w_valid_next = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      w_ready_next = (w_state_next == S_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_l     <= '0;
         r_r     <= '0;
         r_c     <= '0;
         r_d     <= '0;
         r_k     <= '0;
         r_pt    <= '0;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_l     <= w_l_next;
         r_r     <= w_r_next;
         r_c     <= w_c_next;
         r_d     <= w_d_next;
         r_k     <= w_k_next;
         r_pt    <= w_pt_next;
         r_valid <= w_valid_next;
         r_ready <= w_ready_next;
      end
   end

   assign o_ready     = r_ready;
   assign o_valid     = r_valid;
   assign o_plaintext = r_pt;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Self-checking bench for des_decrypt_core: known vectors, back-to-back, busy
// garbage, mid-run reset and random pairs encrypted by an in-bench DES model.

module tb_des_decrypt_core;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic [63:0] i_ciphertext;
   logic [63:0] i_key;
   logic        o_ready;
   logic        o_valid;
   logic [63:0] o_plaintext;

   des_decrypt_core dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_ciphertext (i_ciphertext),
      .i_key        (i_key),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_plaintext  (o_plaintext)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference DES encryption model ----------------
   localparam int IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{
      57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam logic [255:0] SBT [8] = '{
      256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
      256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
      256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
      256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
      256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
      256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
      256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
      256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

   function automatic logic [3:0] m_sbox(input int j, input logic [5:0] b);
      int row, col, idx;
      logic [255:0] t;
      row = {b[5], b[0]};
      col = b[4:1];
      idx = row * 16 + col;
      t   = SBT[j];
      return t[255 - 4 * idx -: 4];
   endfunction

   function automatic logic [63:0] des_enc(input logic [63:0] key, input logic [63:0] pt);
      logic [55:0] cd, kcd;
      logic [27:0] c, d;
      logic [63:0] ip, pre, res;
      logic [31:0] l, r, t, s, f;
      logic [47:0] x, ex, sk;
      int sh;
      for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
      for (int i = 0; i < 64; i++) ip[63 - i] = pt[64 - IP_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      l = ip[63:32];
      r = ip[31:0];
      for (int n = 0; n < 16; n++) begin
         sh = (n == 0 || n == 1 || n == 8 || n == 15) ? 1 : 2;
         for (int m = 0; m < sh; m++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         kcd = {c, d};
         for (int i = 0; i < 48; i++) sk[47 - i] = kcd[56 - PC2_T[i]];
         for (int i = 0; i < 48; i++) ex[47 - i] = r[32 - E_T[i]];
         x = ex ^ sk;
         for (int j = 0; j < 8; j++) s[4 * (7 - j) +: 4] = m_sbox(j, x[6 * (7 - j) +: 6]);
         for (int i = 0; i < 32; i++) f[31 - i] = s[32 - P_T[i]];
         t = r;
         r = l ^ f;
         l = t;
      end
      pre = {r, l};
      for (int i = 0; i < 64; i++) res[63 - i] = pre[64 - FP_T[i]];
      return res;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [63:0] pt;
      int          acc;
   } sb_entry_t;

   sb_entry_t sb_q [$];
   sb_entry_t mon_e;
   logic [63:0] last_pt = '0;
   logic        prev_valid = 1'b0;

   always @(negedge i_clk) begin
      if (i_rst) begin
         last_pt    = '0;
         prev_valid = 1'b0;
      end else begin
         if (o_valid) begin
            chk("valid_width", 64'(prev_valid), 64'd0);
            if (sb_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
            else begin
               mon_e = sb_q.pop_front();
               chk("plaintext", o_plaintext, mon_e.pt);
               chk("latency", 64'(cyc - mon_e.acc), 64'd16);
            end
            last_pt = o_plaintext;
         end else begin
            chk("pt_stable", o_plaintext, last_pt);
         end
         prev_valid = o_valid;
      end
   end

   task automatic send(input logic [63:0] ct, input logic [63:0] key, input logic [63:0] pt,
                       input bit hold, output int acc);
      int t;
      t = 0;
      @(negedge i_clk);
      while (!o_ready && t < 40) begin
         @(negedge i_clk);
         t++;
      end
      chk("ready_wait", 64'(o_ready), 64'd1);
      i_valid      = 1'b1;
      i_ciphertext = ct;
      i_key        = key;
      acc          = cyc + 1;
      sb_q.push_back('{pt: pt, acc: acc});
      @(posedge i_clk);
      #1;
      // scramble inputs after acceptance; they must not influence the running block
      i_ciphertext = {$urandom, $urandom};
      i_key        = {$urandom, $urandom};
      if (!hold) i_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 60) begin
         @(negedge i_clk);
         t++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, ad;
      logic [63:0] k, p;
      bit h;
      i_rst        = 1'b1;
      i_valid      = 1'b0;
      i_ciphertext = '0;
      i_key        = '0;
      repeat (3) @(negedge i_clk);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_pt", o_plaintext, 64'd0);
      i_rst = 1'b0;

      // known vectors, including key with parity bits flipped
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, a0);
      drain();
      send(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, a0);
      drain();
      send(64'h0000000000000000, 64'h0F339333EB6C0C72, 64'h8787878787878787, 1'b0, a0);
      drain();
      send(64'h8CA64DE9C1B123A7, 64'h0000000000000000, 64'h0000000000000000, 1'b0, a0);
      drain();

      // back-to-back with i_valid held high
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, a0);
      send(64'h8CA64DE9C1B123A7, 64'h0000000000000000, 64'h0000000000000000, 1'b1, a1);
      send(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, a2);
      chk("spacing_1", 64'(a1 - a0), 64'd17);
      chk("spacing_2", 64'(a2 - a1), 64'd17);
      drain();

      // garbage request while busy is ignored
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, a0);
      repeat (3) @(negedge i_clk);
      i_valid = 1'b1;
      i_ciphertext = 64'hDEADBEEFCAFEF00D;
      i_key = 64'h0123456789ABCDEF;
      @(negedge i_clk);
      i_valid = 1'b0;
      drain();
      repeat (20) @(negedge i_clk);

      // reset in the middle of a block
      send(64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, a0);
      repeat (7) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      sb_q.delete();
      #1;
      chk("midrst_ready", 64'(o_ready), 64'd1);
      chk("midrst_valid", 64'(o_valid), 64'd0);
      chk("midrst_pt", o_plaintext, 64'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (20) @(negedge i_clk);
      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, a0);
      drain();

      // random pairs encrypted by the model
      for (int n = 0; n < 1000; n++) begin
         k = {$urandom, $urandom};
         p = {$urandom, $urandom};
         h = (n < 999) && ($urandom_range(0, 3) == 0);
         send(des_enc(k, p), k, p, h, ad);
      end
      drain();
      repeat (5) @(negedge i_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
